spi_slave_single_cs: RTL and testbench
======================================

Name: spi_slave_single_cs

Overview:
- SPI responder matching the team's single-CS SPI master; the two connect back to back on a bench or across two boards.
- Oversamples SCLK, MOSI and CS_n in the i_Clk domain and deserialises MOSI into bytes.
- Serialises queued TX bytes onto MISO, with a one-byte holding register and a default fill byte on underrun.
- Counts bytes per CS frame so upstream logic can decode multi-byte commands, e.g. 4-byte current-logger register reads.

Parameters:
- SPI_MODE, 0: 0..3; CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]; must match the master.
- MAX_BYTES_PER_CS, 4: byte-count saturation limit within one CS frame.
- DEFAULT_TX_BYTE, 8'hFF: byte shifted out when no TX byte is queued.
- SYNC_STAGES, 2: synchroniser depth on SCLK, MOSI and CS_n (minimum 2).

Ports:
- i_Clk, in, 1: system clock; must be at least 8x SCLK frequency.
- i_Rst, in, 1: synchronous, active-high reset.
- i_TX_Byte, in, 8: byte to send next.
- i_TX_DV, in, 1: TX byte valid; accepted only when o_TX_Ready=1.
- o_TX_Ready, out, 1: holding register empty.
- o_RX_Byte, out, 8: last fully received byte.
- o_RX_DV, out, 1: one-cycle pulse when o_RX_Byte updates.
- o_RX_Count, out, $clog2(MAX_BYTES_PER_CS+1): completed bytes in the current frame.
- o_Frame_Start, out, 1: one-cycle pulse on synchronised CS_n falling edge.
- o_Frame_End, out, 1: one-cycle pulse on synchronised CS_n rising edge.
- o_TX_Underrun, out, 1: one-cycle pulse when DEFAULT_TX_BYTE is loaded instead of queued data.
- i_SPI_Clk, in, 1: SCLK from the master.
- i_SPI_MOSI, in, 1: MOSI from the master.
- o_SPI_MISO, out, 1: MISO data.
- o_SPI_MISO_En, out, 1: MISO output enable; high only while CS is active.
- i_SPI_CS_n, in, 1: active-low chip select.

Behaviour:
- Reset values:
  - o_TX_Ready=1, o_RX_Byte=0, o_RX_Count=0.
  - All pulse outputs 0.
  - o_SPI_MISO=0, o_SPI_MISO_En=0.
  - Holding register empty.
  - Synchroniser registers set to the idle levels CS_n=1 and SCLK=CPOL.
  - State machine in IDLE.
- Edge detection:
  - Synchronise SCLK, MOSI and CS_n, then detect edges by comparing the last two synchronised samples.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
- State machine:
  - IDLE -> ACTIVE on synchronised CS_n falling edge; pulse o_Frame_Start and clear o_RX_Count.
  - ACTIVE -> IDLE on CS_n rising edge; pulse o_Frame_End.
  - In IDLE, ignore SCLK and MOSI edges.
- TX load at frame start:
  - On entering ACTIVE, load the shift-out register from the holding register if full (set o_TX_Ready=1), else from DEFAULT_TX_BYTE with an o_TX_Underrun pulse.
  - For CPHA=0, drive bit 7 onto MISO in the same cycle.
- Sample and shift edges:
  - CPHA=0: sample MOSI on leading edge, shift MISO on trailing edge.
  - CPHA=1: shift MISO on leading edge, sample MOSI on trailing edge.
  - Bit order is MSB first; the 3-bit bit counter wraps 7->0.
- Byte completion, on the 8th sample edge:
  - o_RX_Byte <= assembled byte; o_RX_DV pulses exactly 1 cycle later than that edge is detected.
  - o_RX_Count increments, saturating at MAX_BYTES_PER_CS.
  - The next TX byte is loaded by the same rule as frame start, so back-to-back bytes need no gap.
- CPHA=0 first-bit timing: from the next byte onward the first bit is driven at the trailing edge following the 8th sample.
- CPHA=1 first-bit timing: bit 7 of the next byte is driven on the next leading edge.
- Holding register:
  - Depth 1. Accept on i_TX_DV && o_TX_Ready; o_TX_Ready drops the next cycle.
  - i_TX_DV while o_TX_Ready=0 is ignored.
  - Accept and consume in the same cycle: the consume uses the old contents; the new byte lands and o_TX_Ready=0.
- Mid-byte CS release:
  - Discard the partial byte; no o_RX_DV; bit counter reset to 0.
  - o_RX_Count holds until the next frame start; o_SPI_MISO_En=0.
- Simultaneous CS rising edge and 8th sample edge: CS wins and the byte is discarded.
- Reset mid-frame: everything returns to reset values immediately; the bus is re-acquired only at the next CS falling edge.
- Latency: MISO changes SYNC_STAGES+1 i_Clk cycles after the SCLK pin edge; the master must allow this (SCLK half-period at least 4 i_Clk cycles at SYNC_STAGES=2).

Decomposition:
- Package spi_pkg:
  - SPI_MODE decode constants (CPOL/CPHA extraction).
  - Bit-counter width constant.
  - State enumeration IDLE and ACTIVE.
  - DEFAULT_TX_BYTE default.
- One sub-module, spi_sync_edge: N-stage synchroniser plus rise/fall pulse outputs with parameterised reset level; instantiated for SCLK, MOSI and CS_n (MOSI ignores the edge outputs).

Test Plan:
- Mode 0, i_Clk 16x SCLK, master sends 8'hA5 with 8'h3C queued -> o_RX_DV once; o_RX_Byte=8'hA5; MISO bits read 8'h3C; o_RX_Count=1; no underrun.
- Mode 3, 4-byte frame 8'h01,02,03,04 with bytes 8'hDE,AD,BE,EF fed on each o_TX_Ready -> four o_RX_DV pulses in order; MISO yields DEADBEEF; o_RX_Count=4.
- No TX queued, mode 1, byte 8'h00 -> MISO reads 8'hFF; o_TX_Underrun pulses once at frame start.
- CS released after 5 SCLK cycles -> no o_RX_DV; o_Frame_End pulses; next full frame 8'h81 received correctly.
- 6 bytes in one frame with MAX_BYTES_PER_CS=4 -> six o_RX_DV pulses; o_RX_Count saturates at 4.
- i_Rst asserted after bit 3 of a frame, released, new frame 8'h5A -> outputs at reset values during reset; 8'h5A received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and types for the single-CS SPI responder.
package spi_pkg;

    localparam int unsigned BIT_CNT_W       = 3;
    localparam logic [7:0]  DEFAULT_TX_FILL = 8'hFF;

    typedef enum logic {
        StIdle,
        StActive
    } spi_state_e;

    function automatic logic spi_cpol(input int unsigned mode);
        return mode[1];
    endfunction

    function automatic logic spi_cpha(input int unsigned mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser; edges come from comparing the last two synchronised samples.
module spi_sync_edge #(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // One extra stage beyond the synchroniser holds the previous synchronised sample.
    logic [STAGES:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {(STAGES + 1){RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[STAGES-1:0], din};
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~sync_q[STAGES];
    assign fall  = ~sync_q[STAGES-1] & sync_q[STAGES];

endmodule

// File: rtl/spi_slave_single_cs.sv
// Single-CS SPI responder: oversampled bus, MSB-first byte RX/TX, one-byte TX holding
// register with default fill on underrun, and per-frame byte counting.
module spi_slave_single_cs
    import spi_pkg::*;
#(
    parameter int unsigned SPI_MODE         = 0,
    parameter int unsigned MAX_BYTES_PER_CS = 4,
    parameter logic [7:0]  DEFAULT_TX_BYTE  = DEFAULT_TX_FILL,
    parameter int unsigned SYNC_STAGES      = 2,
    localparam int unsigned CNT_W           = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [7:0]       i_TX_Byte,
    input  logic             i_TX_DV,
    output logic             o_TX_Ready,
    output logic [7:0]       o_RX_Byte,
    output logic             o_RX_DV,
    output logic [CNT_W-1:0] o_RX_Count,
    output logic             o_Frame_Start,
    output logic             o_Frame_End,
    output logic             o_TX_Underrun,
    input  logic             i_SPI_Clk,
    input  logic             i_SPI_MOSI,
    output logic             o_SPI_MISO,
    output logic             o_SPI_MISO_En,
    input  logic             i_SPI_CS_n
);

    localparam logic CPOL = spi_cpol(SPI_MODE);
    localparam logic CPHA = spi_cpha(SPI_MODE);

    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic cs_level, cs_rise, cs_fall;
    logic unused_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(CPOL)) u_sync_sclk (
        .clk(i_Clk), .rst(i_Rst), .din(i_SPI_Clk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_mosi (
        .clk(i_Clk), .rst(i_Rst), .din(i_SPI_MOSI),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_cs (
        .clk(i_Clk), .rst(i_Rst), .din(i_SPI_CS_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    assign unused_sync = ^{mosi_rise, mosi_fall, cs_level};

    logic sclk_lead, sclk_trail, sample_edge, shift_edge;
    assign sclk_lead   = (sclk_rise | sclk_fall) & (sclk_level != CPOL);
    assign sclk_trail  = (sclk_rise | sclk_fall) & (sclk_level == CPOL);
    assign sample_edge = CPHA ? sclk_trail : sclk_lead;
    assign shift_edge  = CPHA ? sclk_lead : sclk_trail;

    spi_state_e           state_q, state_d;
    logic [7:0]           hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [7:0]           tx_shift_q, tx_shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [6:0]           rx_shift_q, rx_shift_d;
    logic [7:0]           rx_byte_q, rx_byte_d;
    logic [CNT_W-1:0]     rx_count_q, rx_count_d;
    logic                 rx_dv_q, rx_dv_d;
    logic                 fstart_q, fstart_d;
    logic                 fend_q, fend_d;
    logic                 underrun_q, underrun_d;
    logic                 miso_q, miso_d;
    logic                 miso_en_q, miso_en_d;
    logic                 load_byte, load_first;
    logic [7:0]           next_byte;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_shift_d  = tx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_count_d  = rx_count_q;
        rx_dv_d     = 1'b0;
        fstart_d    = 1'b0;
        fend_d      = 1'b0;
        underrun_d  = 1'b0;
        miso_d      = miso_q;
        miso_en_d   = miso_en_q;
        load_byte   = 1'b0;
        load_first  = 1'b0;
        next_byte   = hold_full_q ? hold_q : DEFAULT_TX_BYTE;

        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d    = StActive;
                    fstart_d   = 1'b1;
                    rx_count_d = '0;
                    bit_cnt_d  = '0;
                    miso_en_d  = 1'b1;
                    load_byte  = 1'b1;
                    load_first = 1'b1;
                end
            end
            StActive: begin
                // CS release takes priority over a coincident 8th sample edge.
                if (cs_rise) begin
                    state_d   = StIdle;
                    fend_d    = 1'b1;
                    bit_cnt_d = '0;
                    miso_en_d = 1'b0;
                    miso_d    = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = {rx_shift_q[5:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == '1) begin
                            rx_byte_d = {rx_shift_q, mosi_s};
                            rx_dv_d   = 1'b1;
                            load_byte = 1'b1;
                            if (rx_count_q < CNT_W'(MAX_BYTES_PER_CS)) begin
                                rx_count_d = rx_count_q + 1'b1;
                            end
                        end
                    end
                    if (shift_edge) begin
                        miso_d     = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_byte) begin
            if (hold_full_q) begin
                hold_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
            // CPHA=0 has no leading shift edge before the first sample, so bit 7 goes out now.
            if (load_first && !CPHA) begin
                miso_d     = next_byte[7];
                tx_shift_d = {next_byte[6:0], 1'b0};
            end else begin
                tx_shift_d = next_byte;
            end
        end

        if (i_TX_DV && !hold_full_q) begin
            hold_d      = i_TX_Byte;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_count_q  <= '0;
            rx_dv_q     <= 1'b0;
            fstart_q    <= 1'b0;
            fend_q      <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b0;
            miso_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_shift_q  <= tx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_count_q  <= rx_count_d;
            rx_dv_q     <= rx_dv_d;
            fstart_q    <= fstart_d;
            fend_q      <= fend_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
            miso_en_q   <= miso_en_d;
        end
    end

    assign o_TX_Ready    = ~hold_full_q;
    assign o_RX_Byte     = rx_byte_q;
    assign o_RX_DV       = rx_dv_q;
    assign o_RX_Count    = rx_count_q;
    assign o_Frame_Start = fstart_q;
    assign o_Frame_End   = fend_q;
    assign o_TX_Underrun = underrun_q;
    assign o_SPI_MISO    = miso_q;
    assign o_SPI_MISO_En = miso_en_q;

endmodule

// File: tb/tb_spi_slave_single_cs.sv
// Bench for spi_slave_single_cs: three instances (modes 0, 1, 3) driven by a bit-banged master.
module tb_spi_slave_single_cs;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sclk [3];
    logic       mosi [3];
    logic       cs_n [3];
    logic       tx_dv [3];
    logic [7:0] tx_byte [3];
    logic       tx_ready [3];
    logic [7:0] rx_byte [3];
    logic       rx_dv [3];
    logic [2:0] rx_count [3];
    logic       fstart [3];
    logic       fend [3];
    logic       underrun [3];
    logic       miso [3];
    logic       miso_en [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_slave_single_cs #(
            .SPI_MODE((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
            .MAX_BYTES_PER_CS(4),
            .DEFAULT_TX_BYTE(8'hFF),
            .SYNC_STAGES(2)
        ) u_dut (
            .i_Clk(clk), .i_Rst(rst),
            .i_TX_Byte(tx_byte[g]), .i_TX_DV(tx_dv[g]), .o_TX_Ready(tx_ready[g]),
            .o_RX_Byte(rx_byte[g]), .o_RX_DV(rx_dv[g]), .o_RX_Count(rx_count[g]),
            .o_Frame_Start(fstart[g]), .o_Frame_End(fend[g]), .o_TX_Underrun(underrun[g]),
            .i_SPI_Clk(sclk[g]), .i_SPI_MOSI(mosi[g]), .o_SPI_MISO(miso[g]),
            .o_SPI_MISO_En(miso_en[g]), .i_SPI_CS_n(cs_n[g])
        );
    end

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] mo [8];
    logic [7:0] mi [8];
    logic [7:0] fd [8];
    int n_rx [3];
    int n_und [3];
    int n_und_start [3];
    int n_fs [3];
    int n_fe [3];
    logic [7:0] rx_log [3][32];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rx_dv[k] === 1'b1) begin
                if (n_rx[k] < 32) rx_log[k][n_rx[k]] = rx_byte[k];
                n_rx[k]++;
            end
            if (underrun[k] === 1'b1) n_und[k]++;
            if (underrun[k] === 1'b1 && fstart[k] === 1'b1) n_und_start[k]++;
            if (fstart[k] === 1'b1) n_fs[k]++;
            if (fend[k] === 1'b1) n_fe[k]++;
        end
    end

    function automatic int mode_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic queue_tx(input int k, input logic [7:0] b);
        int waited = 0;
        while (tx_ready[k] !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (tx_ready[k] !== 1'b1) begin
            $display("FAIL tx_ready_wait[%0d]: ready=%b, required 1 within 400 cycles",
                     k, tx_ready[k]);
        end else begin
            n_pass++;
            tx_byte[k] = b;
            tx_dv[k] = 1'b1;
            @(negedge clk);
            tx_dv[k] = 1'b0;
        end
    endtask

    task automatic feed_all(input int k, input int n);
        for (int j = 0; j < n; j++) queue_tx(k, fd[j]);
    endtask

    task automatic frame(input int k, input int nbytes, input int nbits_last, input bit keep_cs);
        logic cpol, cpha;
        int nb;
        cpol = (mode_of(k) >= 2);
        cpha = ((mode_of(k) % 2) == 1);
        @(negedge clk);
        cs_n[k] = 1'b0;
        repeat (HALF) @(negedge clk);
        n_checks++;
        if (miso_en[k] !== 1'b1) $display("FAIL miso_en_active[%0d]: got %b, required 1",
                                           k, miso_en[k]);
        else n_pass++;
        for (int j = 0; j < nbytes; j++) begin
            nb = (j == nbytes - 1) ? nbits_last : 8;
            for (int i = 7; i > 7 - nb; i--) begin
                if (!cpha) begin
                    mosi[k] = mo[j][i];
                    repeat (HALF) @(negedge clk);
                    sclk[k] = ~cpol;
                    mi[j][i] = miso[k];
                    repeat (HALF) @(negedge clk);
                    sclk[k] = cpol;
                end else begin
                    sclk[k] = ~cpol;
                    mosi[k] = mo[j][i];
                    repeat (HALF) @(negedge clk);
                    sclk[k] = cpol;
                    mi[j][i] = miso[k];
                    repeat (HALF) @(negedge clk);
                end
            end
        end
        repeat (HALF) @(negedge clk);
        if (!keep_cs) begin
            cs_n[k] = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (tx_ready[k] !== 1'b1) $display("FAIL reset_tx_ready[%0d]: got %b, required 1",
                                                k, tx_ready[k]);
            else n_pass++;
            n_checks++;
            if (rx_byte[k] !== 8'h00 || rx_count[k] !== 3'd0 || rx_dv[k] !== 1'b0)
                $display("FAIL reset_rx[%0d]: byte=%h count=%0d dv=%b, required 00/0/0",
                         k, rx_byte[k], rx_count[k], rx_dv[k]);
            else n_pass++;
            n_checks++;
            if (miso[k] !== 1'b0 || miso_en[k] !== 1'b0 || fstart[k] !== 1'b0 ||
                fend[k] !== 1'b0 || underrun[k] !== 1'b0)
                $display("FAIL reset_outs[%0d]: miso=%b en=%b fs=%b fe=%b ur=%b, required 0",
                         k, miso[k], miso_en[k], fstart[k], fend[k], underrun[k]);
            else n_pass++;
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_mode0_basic();
        int rx0, ur0, fe0;
        rx0 = n_rx[0]; ur0 = n_und[0]; fe0 = n_fe[0];
        queue_tx(0, 8'h3C);
        n_checks++;
        if (tx_ready[0] !== 1'b0) $display("FAIL m0_ready_drop: got %b, required 0", tx_ready[0]);
        else n_pass++;
        mo[0] = 8'hA5;
        fd[0] = 8'h00;
        fork
            frame(0, 1, 8, 1'b0);
            feed_all(0, 1);
        join
        n_checks++;
        if (n_rx[0] - rx0 !== 1) $display("FAIL m0_rx_dv_count: got %0d, required 1", n_rx[0] - rx0);
        else n_pass++;
        n_checks++;
        if (rx_byte[0] !== 8'hA5) $display("FAIL m0_rx_byte: got %h, required a5", rx_byte[0]);
        else n_pass++;
        n_checks++;
        if (mi[0] !== 8'h3C) $display("FAIL m0_miso_byte: got %h, required 3c", mi[0]);
        else n_pass++;
        n_checks++;
        if (rx_count[0] !== 3'd1) $display("FAIL m0_rx_count: got %0d, required 1", rx_count[0]);
        else n_pass++;
        n_checks++;
        if (n_und[0] - ur0 !== 0) $display("FAIL m0_underrun: got %0d, required 0", n_und[0] - ur0);
        else n_pass++;
        n_checks++;
        if (n_fe[0] - fe0 !== 1 || miso_en[0] !== 1'b0)
            $display("FAIL m0_frame_end: ends=%0d en=%b, required 1/0", n_fe[0] - fe0, miso_en[0]);
        else n_pass++;
    endtask

    task automatic test_mode3_multi();
        logic [7:0] ex [4];
        int rx0;
        ex[0] = 8'hDE; ex[1] = 8'hAD; ex[2] = 8'hBE; ex[3] = 8'hEF;
        rx0 = n_rx[2];
        queue_tx(2, 8'hDE);
        mo[0] = 8'h01; mo[1] = 8'h02; mo[2] = 8'h03; mo[3] = 8'h04;
        fd[0] = 8'hAD; fd[1] = 8'hBE; fd[2] = 8'hEF;
        fork
            frame(2, 4, 8, 1'b0);
            feed_all(2, 3);
        join
        n_checks++;
        if (n_rx[2] - rx0 !== 4) $display("FAIL m3_rx_dv_count: got %0d, required 4", n_rx[2] - rx0);
        else n_pass++;
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (rx_log[2][rx0 + j] !== mo[j])
                $display("FAIL m3_rx_byte%0d: got %h, required %h", j, rx_log[2][rx0 + j], mo[j]);
            else n_pass++;
            n_checks++;
            if (mi[j] !== ex[j]) $display("FAIL m3_miso_byte%0d: got %h, required %h", j, mi[j], ex[j]);
            else n_pass++;
        end
        n_checks++;
        if (rx_count[2] !== 3'd4) $display("FAIL m3_rx_count: got %0d, required 4", rx_count[2]);
        else n_pass++;
    endtask

    task automatic test_underrun_mode1();
        int rx0, us0;
        rx0 = n_rx[1]; us0 = n_und_start[1];
        mo[0] = 8'h00;
        frame(1, 1, 8, 1'b0);
        n_checks++;
        if (mi[0] !== 8'hFF) $display("FAIL m1_default_fill: got %h, required ff", mi[0]);
        else n_pass++;
        n_checks++;
        if (n_und_start[1] - us0 !== 1)
            $display("FAIL m1_underrun_at_start: got %0d, required 1", n_und_start[1] - us0);
        else n_pass++;
        n_checks++;
        if (n_rx[1] - rx0 !== 1 || rx_byte[1] !== 8'h00)
            $display("FAIL m1_rx: dv=%0d byte=%h, required 1/00", n_rx[1] - rx0, rx_byte[1]);
        else n_pass++;
    endtask

    task automatic test_cs_abort();
        int rx0, fe0;
        rx0 = n_rx[0]; fe0 = n_fe[0];
        mo[0] = 8'hFF;
        frame(0, 1, 5, 1'b0);
        n_checks++;
        if (n_rx[0] - rx0 !== 0) $display("FAIL abort_no_dv: got %0d, required 0", n_rx[0] - rx0);
        else n_pass++;
        n_checks++;
        if (n_fe[0] - fe0 !== 1) $display("FAIL abort_frame_end: got %0d, required 1", n_fe[0] - fe0);
        else n_pass++;
        n_checks++;
        if (rx_count[0] !== 3'd0 || miso_en[0] !== 1'b0)
            $display("FAIL abort_state: count=%0d en=%b, required 0/0", rx_count[0], miso_en[0]);
        else n_pass++;
        rx0 = n_rx[0];
        mo[0] = 8'h81;
        frame(0, 1, 8, 1'b0);
        n_checks++;
        if (n_rx[0] - rx0 !== 1 || rx_byte[0] !== 8'h81)
            $display("FAIL abort_next_frame: dv=%0d byte=%h, required 1/81", n_rx[0] - rx0, rx_byte[0]);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int rx0;
        rx0 = n_rx[0];
        mo[0] = 8'h11; mo[1] = 8'h22; mo[2] = 8'h33; mo[3] = 8'h44; mo[4] = 8'h55; mo[5] = 8'h66;
        frame(0, 6, 8, 1'b0);
        n_checks++;
        if (n_rx[0] - rx0 !== 6) $display("FAIL sat_dv_count: got %0d, required 6", n_rx[0] - rx0);
        else n_pass++;
        n_checks++;
        if (rx_count[0] !== 3'd4) $display("FAIL sat_rx_count: got %0d, required 4", rx_count[0]);
        else n_pass++;
        n_checks++;
        if (rx_log[0][rx0 + 4] !== 8'h55 || rx_byte[0] !== 8'h66)
            $display("FAIL sat_late_bytes: b4=%h last=%h, required 55/66", rx_log[0][rx0 + 4], rx_byte[0]);
        else n_pass++;
        n_checks++;
        if (mi[5] !== 8'hFF) $display("FAIL sat_fill: got %h, required ff", mi[5]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int rx0;
        mo[0] = 8'hC3;
        frame(0, 1, 3, 1'b1);
        queue_tx(0, 8'h77);
        @(negedge clk);
        rst = 1'b1;
        cs_n[0] = 1'b1;
        sclk[0] = 1'b0;
        mosi[0] = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (tx_ready[0] !== 1'b1 || rx_byte[0] !== 8'h00 || rx_count[0] !== 3'd0)
            $display("FAIL rst_mid_regs: ready=%b byte=%h count=%0d, required 1/00/0",
                     tx_ready[0], rx_byte[0], rx_count[0]);
        else n_pass++;
        n_checks++;
        if (miso[0] !== 1'b0 || miso_en[0] !== 1'b0 || rx_dv[0] !== 1'b0)
            $display("FAIL rst_mid_outs: miso=%b en=%b dv=%b, required 0/0/0",
                     miso[0], miso_en[0], rx_dv[0]);
        else n_pass++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rx0 = n_rx[0];
        mo[0] = 8'h5A;
        frame(0, 1, 8, 1'b0);
        n_checks++;
        if (n_rx[0] - rx0 !== 1 || rx_byte[0] !== 8'h5A || rx_count[0] !== 3'd1)
            $display("FAIL rst_next_frame: dv=%0d byte=%h count=%0d, required 1/5a/1",
                     n_rx[0] - rx0, rx_byte[0], rx_count[0]);
        else n_pass++;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            sclk[k] = (mode_of(k) >= 2);
            mosi[k] = 1'b0;
            cs_n[k] = 1'b1;
            tx_dv[k] = 1'b0;
            tx_byte[k] = 8'h00;
        end
        test_reset();
        test_mode0_basic();
        test_mode3_multi();
        test_underrun_mode1();
        test_cs_abort();
        test_saturation();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench still running at 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
